// File: rtl/nonogram_pkg.sv
// ============================================================================
//  Module      : nonogram_pkg
//  Description : Shared phase and error encodings for the nonogram engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package nonogram_pkg;

  localparam int LINE_WIDTH = 16;

  typedef enum logic [2:0] {
    PH_RECEIVE     = 3'd0,
    PH_START_SOLVE = 3'd1,
    PH_SOLVE       = 3'd2,
    PH_TRANSMIT    = 3'd3,
    PH_DRAIN       = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_t;

endpackage

`default_nettype wire

// File: rtl/activity_watchdog.sv
// ============================================================================
//  Module      : activity_watchdog
//  Description : Saturating idle counter; flags expiry after TIMEOUT quiet cycles.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module activity_watchdog #(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic clear,
  input  logic activity,
  output logic expired
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_SAT   = c_CNT_W'(TIMEOUT);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk_50mhz) begin
    if (rst || clear || activity) begin
      r_count <= '0;
    end else if (r_count != c_SAT) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  // An access on the final cycle rescues the solver.
  assign expired = (r_count == c_LAST) && !activity;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
//  Module      : phase_sequencer
//  Description : Receive/solve/transmit/drain sequencer with FIFO arbitration.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module phase_sequencer
  import nonogram_pkg::*;
#(
  parameter int DATA_WIDTH    = LINE_WIDTH,
  parameter int SOLVE_TIMEOUT = 50_000_000
) (
  input  logic                  clk_50mhz,
  input  logic                  rst,
  input  logic                  parse_wr,
  input  logic [DATA_WIDTH-1:0] parse_line,
  input  logic                  parse_done,
  input  logic                  solve_wr,
  input  logic [DATA_WIDTH-1:0] solve_line,
  input  logic                  solve_rd,
  input  logic                  solve_done,
  input  logic                  assemble_done,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_rd,
  output logic                  solve_start,
  output logic                  assemble_start,
  output logic [2:0]            phase,
  output logic                  error,
  output logic [1:0]            err_code
);

  phase_t r_state;
  phase_t w_next;
  logic   r_error;
  err_t   r_err_code;
  logic   r_solve_start;
  logic   r_assemble_start;

  logic   w_fault;
  err_t   w_fault_code;
  logic   w_expired;
  logic   w_wd_clear;
  logic   w_solve_access;

  // Derived straight from inputs so the watchdog has no path back through the mux.
  assign w_wd_clear     = (r_state == PH_START_SOLVE);
  assign w_solve_access = (r_state == PH_SOLVE) &&
                          ((solve_wr && !fifo_full) || (solve_rd && !fifo_empty));

  activity_watchdog #(
    .TIMEOUT (SOLVE_TIMEOUT)
  ) u_watchdog (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .clear     (w_wd_clear),
    .activity  (w_solve_access),
    .expired   (w_expired)
  );

  always_comb begin
    w_next       = r_state;
    fifo_wr      = 1'b0;
    fifo_rd      = 1'b0;
    fifo_din     = '0;
    w_fault      = 1'b0;
    w_fault_code = ERR_NONE;

    case (r_state)
      PH_RECEIVE: begin
        fifo_wr  = parse_wr && !fifo_full;
        fifo_din = parse_line;
        if (parse_wr && fifo_full) begin
          w_fault      = 1'b1;
          w_fault_code = ERR_OVERFLOW;
          w_next       = PH_DRAIN;
        end else if (parse_done) begin
          w_next = PH_START_SOLVE;
        end
      end
      PH_START_SOLVE: begin
        w_next = PH_SOLVE;
      end
      PH_SOLVE: begin
        fifo_wr  = solve_wr && !fifo_full;
        fifo_din = solve_line;
        fifo_rd  = solve_rd && !fifo_empty;
        // Overflow beats completion, completion beats timeout.
        if (solve_wr && fifo_full) begin
          w_fault      = 1'b1;
          w_fault_code = ERR_OVERFLOW;
          w_next       = PH_DRAIN;
        end else if (solve_done) begin
          w_next = PH_TRANSMIT;
        end else if (w_expired) begin
          w_fault      = 1'b1;
          w_fault_code = ERR_TIMEOUT;
          w_next       = PH_DRAIN;
        end
      end
      PH_TRANSMIT: begin
        if (assemble_done) begin
          w_next = PH_DRAIN;
        end
      end
      PH_DRAIN: begin
        fifo_rd = !fifo_empty;
        if (fifo_empty) begin
          w_next = PH_RECEIVE;
        end
      end
      default: begin
        w_next = PH_RECEIVE;
      end
    endcase

    if (rst) begin
      fifo_wr  = 1'b0;
      fifo_rd  = 1'b0;
      fifo_din = '0;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state          <= PH_RECEIVE;
      r_error          <= 1'b0;
      r_err_code       <= ERR_NONE;
      r_solve_start    <= 1'b0;
      r_assemble_start <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_solve_start    <= (r_state == PH_RECEIVE) && (w_next == PH_START_SOLVE);
      r_assemble_start <= (r_state == PH_SOLVE) && (w_next == PH_TRANSMIT);
      // Only the first fault is recorded.
      if (w_fault && !r_error) begin
        r_error    <= 1'b1;
        r_err_code <= w_fault_code;
      end
    end
  end

  assign phase          = r_state;
  assign error          = r_error;
  assign err_code       = r_err_code;
  assign solve_start    = r_solve_start;
  assign assemble_start = r_assemble_start;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Randomized scoreboard bench for phase_sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

  localparam int DW    = 16;
  localparam int TMO   = 100;
  localparam int DEPTH = 32;

  logic          clk_50mhz = 1'b0;
  logic          rst = 1'b1;
  logic          parse_wr = 1'b0, parse_done = 1'b0;
  logic [DW-1:0] parse_line = '0, solve_line = '0;
  logic          solve_wr = 1'b0, solve_rd = 1'b0, solve_done = 1'b0;
  logic          assemble_done = 1'b0;
  logic          force_full = 1'b0;
  logic          r_mdl_full = 1'b0, r_mdl_empty = 1'b1;
  logic          fifo_full, fifo_empty;
  logic          fifo_wr, fifo_rd, solve_start, assemble_start, error;
  logic [DW-1:0] fifo_din;
  logic [2:0]    phase;
  logic [1:0]    err_code;

  assign fifo_full  = force_full | r_mdl_full;
  assign fifo_empty = r_mdl_empty;

  phase_sequencer #(.DATA_WIDTH(DW), .SOLVE_TIMEOUT(TMO)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst),
    .parse_wr(parse_wr), .parse_line(parse_line), .parse_done(parse_done),
    .solve_wr(solve_wr), .solve_line(solve_line), .solve_rd(solve_rd),
    .solve_done(solve_done), .assemble_done(assemble_done),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .solve_start(solve_start), .assemble_start(assemble_start),
    .phase(phase), .error(error), .err_code(err_code)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Line FIFO model shared by parser and solver.
  logic [DW-1:0] mdl_q[$];
  always @(posedge clk_50mhz) begin
    if (rst) mdl_q.delete();
    else begin
      if (fifo_rd && mdl_q.size() > 0) void'(mdl_q.pop_front());
      if (fifo_wr && mdl_q.size() < DEPTH) mdl_q.push_back(fifo_din);
    end
    r_mdl_empty <= (mdl_q.size() == 0);
    r_mdl_full  <= (mdl_q.size() >= DEPTH);
  end

  int            n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_wr[$];
  int            exp_rd = 0, exp_ss = 0, exp_as = 0;

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] req);
    n_fail++;
    $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) fail_line(name, act, req);
  endtask

  // Monitor: every strobe the DUT presents must match a pending expectation.
  always @(negedge clk_50mhz) begin
    if (fifo_wr === 1'b1) begin
      n_tests++;
      if (exp_wr.size() == 0) fail_line("unexpected fifo_wr", 32'(fifo_din), 0);
      else begin
        logic [DW-1:0] e;
        e = exp_wr.pop_front();
        if (fifo_din !== e) fail_line("fifo_din", 32'(fifo_din), 32'(e));
      end
    end
    if (fifo_rd === 1'b1) begin
      n_tests++;
      if (exp_rd == 0) fail_line("unexpected fifo_rd", 1, 0);
      else exp_rd--;
    end
    if (solve_start === 1'b1) begin
      n_tests++;
      if (exp_ss == 0) fail_line("unexpected solve_start", 1, 0);
      else exp_ss--;
    end
    if (assemble_start === 1'b1) begin
      n_tests++;
      if (exp_as == 0) fail_line("unexpected assemble_start", 1, 0);
      else exp_as--;
    end
  end

  task automatic cyc();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic idle();
    parse_wr = 0; parse_done = 0; solve_wr = 0; solve_rd = 0;
    solve_done = 0; assemble_done = 0;
    parse_line = DW'($urandom); solve_line = DW'($urandom);
  endtask

  task automatic noise_solver();
    solve_wr = 1'($urandom); solve_rd = 1'($urandom); solve_done = 1'($urandom);
    solve_line = DW'($urandom);
  endtask

  task automatic noise_parser();
    parse_wr = 1'($urandom); parse_done = 1'($urandom); parse_line = DW'($urandom);
  endtask

  task automatic drained(input string tag);
    check({tag, " pending writes"}, exp_wr.size(), 0);
    check({tag, " pending reads"}, exp_rd, 0);
    check({tag, " pending solve_start"}, exp_ss, 0);
    check({tag, " pending assemble_start"}, exp_as, 0);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    parse_wr = 1; solve_wr = 1; solve_rd = 1;
    cyc();
    check("rst fifo_wr", fifo_wr, 0);
    check("rst fifo_rd", fifo_rd, 0);
    check("rst fifo_din", fifo_din, 0);
    check("rst phase", phase, 0);
    check("rst error", error, 0);
    check("rst err_code", err_code, 0);
    check("rst solve_start", solve_start, 0);
    check("rst assemble_start", assemble_start, 0);
    cyc();
    rst = 0; idle();
  endtask

  task automatic parse_words(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        idle(); noise_solver(); assemble_done = 1'($urandom); cyc();
      end
      idle(); noise_solver();
      parse_wr = 1; parse_line = DW'($urandom);
      exp_wr.push_back(parse_line);
      cyc();
    end
    idle();
  endtask

  // Ends in the first SOLVE cycle.
  task automatic receive_board(input int n);
    if (n > 0) parse_words(n - 1);
    idle(); noise_solver();
    if (n > 0) begin
      parse_wr = 1; parse_line = DW'($urandom);
      exp_wr.push_back(parse_line);
    end
    parse_done = 1; exp_ss++;
    cyc(); idle();
    check("phase START_SOLVE", phase, 1);
    check("solve_start pulse", solve_start, 1);
    cyc();
    check("phase SOLVE", phase, 2);
    check("solve_start one cycle", solve_start, 0);
  endtask

  task automatic solve_board(input int reads, input int writes);
    int guard = 0;
    while ((reads > 0 || writes > 0) && guard < 500) begin
      idle(); noise_parser(); assemble_done = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (reads > 0 && $urandom_range(0, 1) == 1) begin
          solve_rd = 1;
          if (!fifo_empty) begin exp_rd++; reads--; end
        end
        if (writes > 0 && $urandom_range(0, 1) == 1) begin
          solve_wr = 1; solve_line = DW'($urandom);
          exp_wr.push_back(solve_line); writes--;
        end
      end
      cyc(); guard++;
    end
    idle();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (phase !== 3'd0 && k < 200) begin cyc(); k++; end
    check({tag, " back to RECEIVE"}, phase, 0);
    check({tag, " fifo empty"}, mdl_q.size(), 0);
  endtask

  task automatic transmit_and_drain();
    int gap = $urandom_range(1, 3);
    solve_done = 1; exp_as++;
    cyc(); idle();
    check("phase TRANSMIT", phase, 3);
    check("assemble_start pulse", assemble_start, 1);
    for (int g = 0; g < gap; g++) begin
      noise_parser(); noise_solver(); cyc(); idle();
      if (g == 0) check("assemble_start one cycle", assemble_start, 0);
    end
    assemble_done = 1; exp_rd += mdl_q.size();
    cyc(); idle();
    check("phase DRAIN", phase, 4);
    wait_idle("drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit: actual=%0d required=0", 1);
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();

    // Happy path, then randomized boards.
    receive_board(22);
    solve_board(22, 5);
    transmit_and_drain();
    check("happy error", error, 0);
    drained("happy");
    for (int b = 0; b < 4; b++) begin
      int n = $urandom_range(0, 20);
      receive_board(n);
      solve_board(n, $urandom_range(0, 8));
      transmit_and_drain();
      check("random board error", error, 0);
      drained("random");
    end

    // Overflow while receiving.
    parse_words(3);
    force_full = 1; parse_wr = 1; parse_line = DW'($urandom);
    cyc(); idle();
    check("overflow phase", phase, 4);
    check("overflow error", error, 1);
    check("overflow err_code", err_code, 1);
    force_full = 0; exp_rd += mdl_q.size();
    wait_idle("overflow");
    drained("overflow");

    // Timeout with reads on an empty FIFO; first error code must stick.
    receive_board(0);
    for (int k = 0; k < TMO - 2; k++) cyc();
    solve_rd = 1; cyc(); cyc(); idle();
    check("empty-read timeout phase", phase, 4);
    check("sticky error", error, 1);
    check("sticky err_code", err_code, 1);
    wait_idle("sticky");

    // Reset while solving with 7 words queued.
    receive_board(7);
    cyc(); cyc();
    do_reset();
    check("post-reset fifo empty", mdl_q.size(), 0);
    drained("midsolve reset");

    // Timeout with an access one cycle before expiry.
    receive_board(3);
    for (int k = 0; k < TMO - 1; k++) cyc();
    solve_wr = 1; solve_line = DW'($urandom); exp_wr.push_back(solve_line);
    cyc(); idle();
    for (int k = 0; k < TMO - 1; k++) cyc();
    check("rescued phase", phase, 2);
    check("rescued error", error, 0);
    cyc();
    check("timeout phase", phase, 4);
    check("timeout error", error, 1);
    check("timeout err_code", err_code, 2);
    exp_rd += mdl_q.size();
    wait_idle("timeout");
    drained("timeout");

    // solve_done on the expiry cycle wins.
    do_reset();
    receive_board(1);
    for (int k = 0; k < TMO - 1; k++) cyc();
    transmit_and_drain();
    check("coincident done error", error, 0);
    drained("coincident");

    // Overflow in SOLVE beats a simultaneous solve_done.
    receive_board(2);
    force_full = 1; solve_wr = 1; solve_done = 1;
    cyc(); idle(); force_full = 0;
    check("solve overflow phase", phase, 4);
    check("solve overflow err_code", err_code, 1);
    exp_rd += mdl_q.size();
    wait_idle("solve overflow");
    drained("solve overflow");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
